offchip_mem_bridge: RTL

- Sits directly downstream of the system bus cache path.
- Accepts whole-cache-line read/write requests on the offchip_mem_* channel.
- Serialises each request into a burst of 32-bit word transfers on an external SRAM-style req/ack bus.
- Returns refilled lines to the cache with a one-cycle ready pulse, and reports busy status and bus timeouts.

---
 rtl/offchip_mem_bridge.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/offchip_mem_bridge.sv
// rtl/offchip_mem_bridge.sv - cache-line to 32-bit SRAM-style word burst bridge
//
// Purpose:
//    Accepts whole-line read/write requests from the cache path and runs each
//    one as a burst of 32-bit word transfers on an external req/ack bus. Read
//    lines are assembled in offchip_mem_data, completion is a one-cycle ready
//    pulse, and a per-word ack timeout aborts the burst and sets a sticky err.
//
// Ports:
//    clk, rst                 clock, asynchronous active-low reset
//    offchip_mem_read_en      line read request (level)
//    offchip_mem_write_en     line write request (level, wins over read)
//    offchip_mem_addr         line address, low log2(LINE_BYTES) bits ignored
//    offchip_mem_wdata        write line, word k at [32k+31:32k]
//    offchip_mem_data         last completed read line, same word order
//    offchip_mem_ready        one-cycle completion pulse
//    offchip_mem_read_busy    high while a read burst runs
//    offchip_mem_write_busy   high while a write burst runs
//    offchip_mem_err          last request timed out, sticky until next accept
//    ext_req/we/addr/wdata    registered word request towards the SRAM bus
//    ext_rdata, ext_ack       read word and per-word acknowledge
module offchip_mem_bridge #(
   parameter int LINE_BYTES     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    offchip_mem_read_en,
   input  logic                    offchip_mem_write_en,
   input  logic [31:0]             offchip_mem_addr,
   input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
   output logic [LINE_BYTES*8-1:0] offchip_mem_data,
   output logic                    offchip_mem_ready,
   output logic                    offchip_mem_read_busy,
   output logic                    offchip_mem_write_busy,
   output logic                    offchip_mem_err,
   output logic                    ext_req,
   output logic                    ext_we,
   output logic [31:0]             ext_addr,
   output logic [31:0]             ext_wdata,
   input  logic [31:0]             ext_rdata,
   input  logic                    ext_ack
);

   localparam int LW    = LINE_BYTES * 8;
   localparam int NW    = LINE_BYTES / 4;
   localparam int IDX_W = $clog2(NW);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]      LINE_MSK = ~32'(LINE_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_BURST,
      S_WR_BURST,
      S_DONE,
      S_WAIT_LOW
   } state_t;

   state_t           r_state;
   logic [31:0]      r_base;
   logic [LW-1:0]    r_wline;
   logic [LW-1:0]    r_rline;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_tmo;
   logic             r_ready;
   logic             r_rd_busy;
   logic             r_wr_busy;
   logic             r_err;
   logic             r_ext_req;
   logic             r_ext_we;
   logic [31:0]      r_ext_addr;
   logic [31:0]      r_ext_wdata;

   logic [31:0]      w_base_aligned;
   logic [IDX_W-1:0] w_next_idx;
   logic [31:0]      w_next_addr;
   logic [31:0]      w_next_wword;
   logic             w_last;

   // Base is line aligned, so base + 4*index never carries out of the line.
   assign w_base_aligned = offchip_mem_addr & LINE_MSK;
   assign w_next_idx     = r_idx + 1'b1;
   assign w_next_addr    = r_base + {{(30-IDX_W){1'b0}}, w_next_idx, 2'b00};
   assign w_next_wword   = r_wline[32*int'(w_next_idx) +: 32];
   assign w_last         = (r_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_wline     <= '0;
         r_rline     <= '0;
         r_idx       <= '0;
         r_tmo       <= '0;
         r_ready     <= 1'b0;
         r_rd_busy   <= 1'b0;
         r_wr_busy   <= 1'b0;
         r_err       <= 1'b0;
         r_ext_req   <= 1'b0;
         r_ext_we    <= 1'b0;
         r_ext_addr  <= '0;
         r_ext_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Write first so a dirty writeback lands before its refill.
               if (offchip_mem_write_en) begin
                  r_base      <= w_base_aligned;
                  r_wline     <= offchip_mem_wdata;
                  r_idx       <= '0;
                  r_tmo       <= '0;
                  r_err       <= 1'b0;
                  r_ext_req   <= 1'b1;
                  r_ext_we    <= 1'b1;
                  r_ext_addr  <= w_base_aligned;
                  r_ext_wdata <= offchip_mem_wdata[31:0];
                  r_wr_busy   <= 1'b1;
                  r_state     <= S_WR_BURST;
               end else if (offchip_mem_read_en) begin
                  r_base      <= w_base_aligned;
                  r_idx       <= '0;
                  r_tmo       <= '0;
                  r_err       <= 1'b0;
                  r_ext_req   <= 1'b1;
                  r_ext_we    <= 1'b0;
                  r_ext_addr  <= w_base_aligned;
                  r_ext_wdata <= '0;
                  r_rd_busy   <= 1'b1;
                  r_state     <= S_RD_BURST;
               end
            end

            S_RD_BURST, S_WR_BURST: begin
               if (ext_ack) begin
                  if (r_state == S_RD_BURST) begin
                     r_rline[32*int'(r_idx) +: 32] <= ext_rdata;
                  end
                  r_idx <= w_next_idx;
                  r_tmo <= '0;
                  if (w_last) begin
                     r_ext_req <= 1'b0;
                     r_ext_we  <= 1'b0;
                     r_rd_busy <= 1'b0;
                     r_wr_busy <= 1'b0;
                     r_ready   <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     // Next word goes out on the very next cycle.
                     r_ext_addr  <= w_next_addr;
                     r_ext_wdata <= (r_state == S_WR_BURST) ? w_next_wword : 32'h0;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  // Abort: partial read words stay in the line, err tells the truth.
                  r_ext_req <= 1'b0;
                  r_ext_we  <= 1'b0;
                  r_rd_busy <= 1'b0;
                  r_wr_busy <= 1'b0;
                  r_err     <= 1'b1;
                  r_ready   <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end

            S_DONE: begin
               r_ready <= 1'b0;
               r_state <= S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
               // A level-held request must drop before another is accepted.
               if (!offchip_mem_read_en && !offchip_mem_write_en) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign offchip_mem_data       = r_rline;
   assign offchip_mem_ready      = r_ready;
   assign offchip_mem_read_busy  = r_rd_busy;
   assign offchip_mem_write_busy = r_wr_busy;
   assign offchip_mem_err        = r_err;
   assign ext_req                = r_ext_req;
   assign ext_we                 = r_ext_we;
   assign ext_addr               = r_ext_addr;
   assign ext_wdata              = r_ext_wdata;

endmodule
